kyber_stream_gearbox: RTL and testbench

Parametrised narrow-to-wide stream packer with FIFO buffering and packet framing, sitting between the Kyber server's 32-bit output stream and the Kyber client's wide input bus. Narrow beats are packed lane-by-lane into wide words, queued in a DEPTH-entry FIFO and presented on a valid/ready wide interface. A last flag closes a packet early: the remaining lanes are zero-padded and the packet boundary is carried to the wide side.

---
 rtl/kyber_stream_gearbox_if.sv | 28 ++
 rtl/kyber_stream_gearbox.sv | 82 ++++++++
 tb/tb_kyber_stream_gearbox.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/kyber_stream_gearbox_if.sv
// kyber_stream_gearbox_if: narrow-in / wide-out stream bundle; slave = gearbox, master = surrounding logic
interface kyber_stream_gearbox_if #(
    parameter int NW    = 32,
    parameter int RATIO = 8,
    parameter int DEPTH = 4
);
    logic                       flush;
    logic                       in_valid;
    logic [NW-1:0]              in_data;
    logic                       in_last;
    logic                       in_ready;
    logic                       out_valid;
    logic [NW*RATIO-1:0]        out_data;
    logic                       out_last;
    logic                       out_ready;
    logic [$clog2(DEPTH):0]     fill;
    logic [$clog2(RATIO)-1:0]   lane;

    modport slave (
        input  flush, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, fill, lane
    );

    modport master (
        output flush, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, fill, lane
    );
endinterface

// File: rtl/kyber_stream_gearbox.sv
// kyber_stream_gearbox: packs NW-bit beats into NW*RATIO-bit words through a DEPTH-word FIFO; define KYBER_GB_BYTESWAP_EN to byte-reverse each beat
module kyber_stream_gearbox #(
    parameter int NW    = 32,
    parameter int RATIO = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    kyber_stream_gearbox_if.slave bus
);
    localparam int WW = NW * RATIO;
    localparam int LW = $clog2(RATIO);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL      = (PW+1)'(DEPTH);
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [WW-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] last_q;
    logic [WW-1:0] pack_q, pack_d, word;
    logic [LW-1:0] lane_q, lane_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   fill_q, fill_d;
    logic [NW-1:0] beat;
    logic          acc, done, pop;

`ifdef KYBER_GB_BYTESWAP_EN
    function automatic logic [NW-1:0] swap(input logic [NW-1:0] b);
        logic [NW-1:0] r;
        for (int i = 0; i < NW/8; i++) r[i*8 +: 8] = b[NW-8-i*8 +: 8];
        return r;
    endfunction
    assign beat = swap(bus.in_data);
`else
    assign beat = bus.in_data;
`endif

    // No full-bypass: a pop in the same cycle does not open the input when full
    assign bus.in_ready  = (fill_q != FULL) && !bus.flush;
    assign bus.out_valid = fill_q != '0;
    assign bus.out_data  = mem_q[rptr_q];
    assign bus.out_last  = last_q[rptr_q];
    assign bus.fill      = fill_q;
    assign bus.lane      = lane_q;

    assign acc  = bus.in_valid && bus.in_ready;
    assign done = acc && (lane_q == LAST_LANE || bus.in_last);
    assign pop  = bus.out_valid && bus.out_ready && !bus.flush;
    // Unwritten lanes are already zero, so OR-merging the current beat yields the padded word
    assign word = pack_q | (WW'(beat) << (32'(lane_q) * NW));

    // Next-state for packer, lane index, pointers and occupancy; flush wins over everything
    always_comb begin
        pack_d = bus.flush || done ? '0 : acc ? word : pack_q;
        lane_d = bus.flush || done ? '0 : acc ? lane_q + 1'b1 : lane_q;
        wptr_d = bus.flush ? '0 : wptr_q + PW'(done);
        rptr_d = bus.flush ? '0 : rptr_q + PW'(pop);
        fill_d = bus.flush ? '0 : fill_q + (PW+1)'(done) - (PW+1)'(pop);
    end

    // State registers and FIFO storage, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            last_q <= '0;
            pack_q <= '0;
            lane_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (done) begin
                mem_q[wptr_q]  <= word;
                last_q[wptr_q] <= bus.in_last;
            end
            pack_q <= pack_d;
            lane_q <= lane_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
        end
    end
endmodule

// File: tb/tb_kyber_stream_gearbox.sv
// tb_kyber_stream_gearbox: directed and random stimulus against a queue-based packing model
module tb_kyber_stream_gearbox;
    localparam int NW = 32, RATIO = 8, DEPTH = 4, WW = NW * RATIO;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kyber_stream_gearbox_if #(.NW(NW), .RATIO(RATIO), .DEPTH(DEPTH)) bus ();
    kyber_stream_gearbox #(.NW(NW), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [NW-1:0] pk[$];
    logic [WW-1:0] wq[$];
    bit lq[$];

    function automatic logic [NW-1:0] mk(input logic [NW-1:0] b);
`ifdef KYBER_GB_BYTESWAP_EN
        logic [NW-1:0] r;
        for (int i = 0; i < NW/8; i++) r[i*8 +: 8] = b[NW-8-i*8 +: 8];
        return r;
`else
        return b;
`endif
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [NW-1:0] d, input bit l, input bit r, input bit f);
        logic [WW-1:0] w;
        bit rdy;
        bus.in_valid = v; bus.in_data = d; bus.in_last = l; bus.out_ready = r; bus.flush = f;
        @(negedge clk);
        rdy = (wq.size() < DEPTH) && !f;
        chk("in_ready", bus.in_ready, rdy);
        chk("out_valid", bus.out_valid, wq.size() != 0);
        chk("fill", bus.fill, wq.size());
        chk("lane", bus.lane, pk.size());
        if (wq.size() != 0) begin
            chk("out_data", bus.out_data, wq[0]);
            chk("out_last", bus.out_last, lq[0]);
        end
        if (f) begin
            pk.delete(); wq.delete(); lq.delete();
        end else begin
            if (wq.size() != 0 && r) begin
                void'(wq.pop_front()); void'(lq.pop_front());
            end
            if (v && rdy) begin
                pk.push_back(mk(d));
                if (pk.size() == RATIO || l) begin
                    w = '0;
                    foreach (pk[i]) w[i*NW +: NW] = pk[i];
                    wq.push_back(w); lq.push_back(l);
                    pk.delete();
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [WW-1:0] e;
        logic [NW-1:0] cnt;
        bus.flush = 0; bus.in_valid = 1; bus.in_data = 32'hDEAD; bus.in_last = 1; bus.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_fill", bus.fill, 0);
        chk("rst_lane", bus.lane, 0);
        bus.in_valid = 0;
        rst_n = 1;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        for (int k = 0; k < RATIO; k++) cyc(1, NW'(k + 1), k == RATIO - 1, 1, 0);
        e = '0;
        for (int k = 0; k < RATIO; k++) e[k*NW +: NW] = mk(NW'(k + 1));
        chk("pack8_valid", bus.out_valid, 1);
        chk("pack8_data", bus.out_data, e);
        chk("pack8_last", bus.out_last, 1);
        cyc(0, 0, 0, 1, 0);

        cyc(1, 32'hA, 0, 1, 0);
        cyc(1, 32'hB, 0, 1, 0);
        cyc(1, 32'hC, 1, 1, 0);
        e = '0;
        e[NW-1:0] = mk(32'hA); e[2*NW-1:NW] = mk(32'hB); e[3*NW-1:2*NW] = mk(32'hC);
        chk("short_data", bus.out_data, e);
        chk("short_last", bus.out_last, 1);
        chk("short_lane", bus.lane, 0);
        cyc(0, 0, 0, 1, 0);

        cnt = 32'h100;
        for (int k = 0; k < 40; k++) begin cyc(1, cnt, 0, 0, 0); cnt++; end
        chk("bp_fill", bus.fill, DEPTH);
        chk("bp_ready", bus.in_ready, 0);
        chk("bp_lane", bus.lane, 0);
        for (int k = 0; k < 20; k++) begin cyc(1, cnt, 0, 1, 0); cnt++; end
        cyc(1, cnt, 1, 1, 0);
        repeat (8) cyc(0, 0, 0, 1, 0);

        cyc(1, 32'h1, 1, 0, 0);
        cyc(1, 32'h2, 1, 0, 0);
        for (int k = 0; k < 5; k++) cyc(1, NW'(32'h50 + k), 0, 0, 0);
        chk("fl_fill_pre", bus.fill, 2);
        chk("fl_lane_pre", bus.lane, 5);
        cyc(1, 32'h77, 1, 1, 1);
        chk("fl_fill", bus.fill, 0);
        chk("fl_lane", bus.lane, 0);
        chk("fl_valid", bus.out_valid, 0);
        for (int k = 0; k < RATIO; k++) cyc(1, NW'(32'h60 + k), 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        cyc(1, 32'h11223344, 1, 0, 0);
`ifdef KYBER_GB_BYTESWAP_EN
        chk("swap_lane0", bus.out_data[NW-1:0], 32'h44332211);
`else
        chk("swap_lane0", bus.out_data[NW-1:0], 32'h11223344);
`endif
        cyc(0, 0, 0, 1, 0);

        for (int k = 0; k < 600; k++)
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);

        for (int k = 0; k < 6; k++) cyc(1, NW'(k), k == 2, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_fill", bus.fill, 0);
        chk("mrst_lane", bus.lane, 0);
        chk("mrst_data", bus.out_data, 0);
        pk.delete(); wq.delete(); lq.delete();
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 30; k++)
            cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
